// File: rtl/seq_adder_pkg.sv
// Shared types and helpers for the chunked sequential adder/subtractor.
// Holds the FSM state encoding, the counter-width helper and the full-adder cell.
package seq_adder_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Width of a counter that must hold 0..n-1; never narrower than one bit.
   function automatic int cnt_width(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

   // One full-adder cell: returns {carry_out, sum}.
   function automatic logic [1:0] full_add(input logic x, input logic y, input logic ci);
      return {(x & y) | (ci & (x ^ y)), x ^ y ^ ci};
   endfunction

endpackage

// File: rtl/ripple_add_n.sv
// Combinational N-bit ripple-carry adder built from full-adder cells.
// Also exports the carry into the top bit so the caller can derive signed overflow.
module ripple_add_n
   import seq_adder_pkg::*;
#(
   parameter int N = 4
) (
   input  logic [N-1:0] x,
   input  logic [N-1:0] y,
   input  logic         ci,
   output logic [N-1:0] s,
   output logic         co,
   output logic         c_msb_in
);

   always_comb begin
      logic       cc;
      logic [1:0] fa;
      cc       = ci;
      c_msb_in = ci;
      s        = '0;
      fa       = '0;
      for (int i = 0; i < N; i++) begin
         if (i == N - 1) c_msb_in = cc;
         fa   = full_add(x[i], y[i], cc);
         s[i] = fa[0];
         cc   = fa[1];
      end
      co = cc;
   end

endmodule

// File: rtl/seq_chunk_adder.sv
// Multi-cycle WIDTH-bit adder/subtractor: one CHUNK-bit slice per clock, carry registered
// between slices, with valid/ready handshakes on both sides.
module seq_chunk_adder
   import seq_adder_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int CHUNK = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf,
   output logic             busy
);

   // Handshake: a transfer happens on a rising edge where valid and ready are both high.
   // in_ready is high only in IDLE; out_valid only in DONE, holding results until out_ready.

   localparam int NCH = WIDTH / CHUNK;
   localparam int CW  = cnt_width(NCH);
   localparam logic [CW-1:0] IDX_LAST = CW'(NCH - 1);

   state_t           state;
   state_t           state_nx;
   logic [CW-1:0]    idx;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic [WIDTH-1:0] sum_q;
   logic             carry;
   logic             cout_q;
   logic             ovf_q;
   logic [CHUNK-1:0] ch_s;
   logic             ch_co;
   logic             ch_cm;
   logic             last;
   logic             accept;
   logic             take;

   assign last   = (idx == IDX_LAST);
   assign accept = (state == IDLE) && in_valid;
   assign take   = (state == DONE) && out_ready;

   // Operands shift right each RUN cycle so the active chunk always sits in the low bits.
   ripple_add_n #(.N(CHUNK)) u_add (
      .x        (op_a[CHUNK-1:0]),
      .y        (op_b[CHUNK-1:0]),
      .ci       (carry),
      .s        (ch_s),
      .co       (ch_co),
      .c_msb_in (ch_cm)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (accept) state_nx = RUN;
         RUN:     if (last)   state_nx = DONE;
         DONE:    if (take)   state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (state == IDLE);
      out_valid = (state == DONE);
      busy      = (state != IDLE);
      sum       = sum_q;
      cout      = cout_q;
      ovf       = ovf_q;
   end

   // Subtraction folds into the capture: A + ~B + 1.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx    <= '0;
         op_a   <= '0;
         op_b   <= '0;
         sum_q  <= '0;
         carry  <= 1'b0;
         cout_q <= 1'b0;
         ovf_q  <= 1'b0;
      end else if (accept) begin
         idx   <= '0;
         op_a  <= a;
         op_b  <= sub ? ~b : b;
         carry <= sub | cin;
      end else if (state == RUN) begin
         op_a  <= op_a >> CHUNK;
         op_b  <= op_b >> CHUNK;
         carry <= ch_co;
         // New chunk enters at the top; after NCH cycles chunk 0 has reached the bottom.
         sum_q <= (sum_q >> CHUNK) | (WIDTH'(ch_s) << (WIDTH - CHUNK));
         if (last) begin
            cout_q <= ch_co;
            ovf_q  <= ch_cm ^ ch_co;
         end else begin
            idx <= idx + 1'b1;
         end
      end
   end

endmodule
